// File: rtl/cpu_pkg.sv
// Shared opcode, micro-state and ALU mode definitions for the CPU core controller.
package cpu_pkg;

  // Micro-state codes, as seen on the state output.
  typedef enum logic [3:0] {
    ST_FETCH_PC   = 4'd0,
    ST_FETCH_INST = 4'd1,
    ST_HALT       = 4'd2,
    ST_JUMP       = 4'd3,
    ST_OUT_A      = 4'd4,
    ST_ALU_OP     = 4'd5,
    ST_RAM_A      = 4'd6,
    ST_RAM_B      = 4'd7,
    ST_LOAD_ADDR  = 4'd8,
    ST_STORE_A    = 4'd9,
    ST_LDI        = 4'd10,
    ST_NEXT       = 4'd11
  } state_t;

  // ALU modes, taken from opcode[5:3] of an ALU instruction.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_INC = 3'd2,
    ALU_DEC = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR  = 3'd5,
    ALU_XOR = 3'd6,
    ALU_NOT = 3'd7
  } alu_mode_t;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_LDB = 8'h02;
  localparam logic [7:0] OP_STA = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;
  localparam logic [7:0] OP_JEZ = 8'h05;
  localparam logic [7:0] OP_JNZ = 8'h06;
  localparam logic [7:0] OP_OUT = 8'h07;
  localparam logic [7:0] OP_HLT = 8'h0F;

  // LDI family: 00010rrr.
  function automatic logic is_ldi(input logic [7:0] op);
    return op[7:3] == 5'b00010;
  endfunction

  // ALU family: 01mmm000.
  function automatic logic is_alu(input logic [7:0] op);
    return (op[7:6] == 2'b01) && (op[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Purely combinational ALU; carry out is no-borrow for the subtracting modes.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  alu_mode_t        i_mode,
  output logic [WIDTH-1:0] o_y,
  output logic             o_cout
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] w_ext;

  // One extra bit on arithmetic results carries the carry / borrow.
  always_comb begin
    w_ext  = '0;
    o_y    = '0;
    o_cout = 1'b0;
    unique case (i_mode)
      ALU_ADD: begin
        w_ext  = {1'b0, i_a} + {1'b0, i_b};
        o_y    = w_ext[WIDTH-1:0];
        o_cout = w_ext[WIDTH];
      end
      ALU_SUB: begin
        w_ext  = {1'b0, i_a} - {1'b0, i_b};
        o_y    = w_ext[WIDTH-1:0];
        o_cout = ~w_ext[WIDTH];
      end
      ALU_INC: begin
        w_ext  = {1'b0, i_a} + ONE;
        o_y    = w_ext[WIDTH-1:0];
        o_cout = w_ext[WIDTH];
      end
      ALU_DEC: begin
        w_ext  = {1'b0, i_a} - ONE;
        o_y    = w_ext[WIDTH-1:0];
        o_cout = ~w_ext[WIDTH];
      end
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      ALU_NOT: o_y = ~i_a;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core_ctrl.sv
// Micro-sequencer, instruction register and program counter of a small 8-bit CPU.
// The micro-state is a pure decode of (cycle, opcode); cycle is the only FSM register.
module cpu_core_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] rega,
  input  logic [WIDTH-1:0] regb,
  output logic [3:0]       state,
  output logic [3:0]       cycle,
  output logic [WIDTH-1:0] opcode,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_cout,
  output logic             eq_zero,
  output logic             jump_taken,
  output logic             halted
);

  logic [3:0]       r_cycle;
  logic [WIDTH-1:0] r_opcode;
  logic [WIDTH-1:0] r_pc;
  state_t           w_state;
  logic [7:0]       w_op;
  logic             w_jump;
  logic             w_pc_inc;

  assign w_op = r_opcode[7:0];

  // Decode micro-state from cycle and opcode; anything past the defined sequence is NEXT.
  always_comb begin
    w_state = ST_NEXT;
    if (r_cycle == 4'd0) begin
      w_state = ST_FETCH_PC;
    end else if (r_cycle == 4'd1) begin
      w_state = ST_FETCH_INST;
    end else if (w_op == OP_HLT) begin
      w_state = ST_HALT;
    end else if (w_op == OP_LDA || w_op == OP_LDB || w_op == OP_STA) begin
      case (r_cycle)
        4'd2:    w_state = ST_FETCH_PC;
        4'd3:    w_state = ST_LOAD_ADDR;
        4'd4:    w_state = (w_op == OP_LDA) ? ST_RAM_A :
                           (w_op == OP_LDB) ? ST_RAM_B : ST_STORE_A;
        default: w_state = ST_NEXT;
      endcase
    end else if (w_op == OP_JMP || w_op == OP_JEZ || w_op == OP_JNZ) begin
      case (r_cycle)
        4'd2:    w_state = ST_FETCH_PC;
        4'd3:    w_state = ST_JUMP;
        default: w_state = ST_NEXT;
      endcase
    end else if (w_op == OP_OUT) begin
      w_state = (r_cycle == 4'd2) ? ST_OUT_A : ST_NEXT;
    end else if (is_ldi(w_op)) begin
      case (r_cycle)
        4'd2:    w_state = ST_FETCH_PC;
        4'd3:    w_state = ST_LDI;
        default: w_state = ST_NEXT;
      endcase
    end else if (is_alu(w_op)) begin
      w_state = (r_cycle == 4'd2) ? ST_ALU_OP : ST_NEXT;
    end
  end

  assign eq_zero = (rega == '0);
  assign w_jump  = (w_state == ST_JUMP) &&
                   ((w_op == OP_JMP) ||
                    (w_op == OP_JEZ &&  eq_zero) ||
                    (w_op == OP_JNZ && !eq_zero));
  assign w_pc_inc = (w_state == ST_FETCH_INST) || (w_state == ST_LOAD_ADDR) ||
                    (w_state == ST_LDI) || (w_state == ST_JUMP);

  // Advance cycle, latch opcode, update pc; HALT freezes everything until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycle  <= '0;
      r_opcode <= '0;
      r_pc     <= '0;
    end else begin
      if (w_state == ST_NEXT)      r_cycle <= '0;
      else if (w_state != ST_HALT) r_cycle <= r_cycle + 4'd1;
      if (w_state == ST_FETCH_INST) r_opcode <= data_in;
      if (w_jump)        r_pc <= data_in;
      else if (w_pc_inc) r_pc <= r_pc + WIDTH'(1);
    end
  end

  cpu_alu #(.WIDTH(WIDTH)) u_alu (
    .i_a    (rega),
    .i_b    (regb),
    .i_mode (alu_mode_t'(r_opcode[5:3])),
    .o_y    (alu_out),
    .o_cout (alu_cout)
  );

  assign state      = w_state;
  assign cycle      = r_cycle;
  assign opcode     = r_opcode;
  assign pc         = r_pc;
  assign jump_taken = w_jump;
  assign halted     = (w_state == ST_HALT);

endmodule

// File: tb/tb_cpu_core_ctrl.sv
// Directed self-checking bench for cpu_core_ctrl.
module tb_cpu_core_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] rega = 8'h00;
  logic [7:0] regb = 8'h00;
  logic [3:0] state, cycle;
  logic [7:0] opcode, pc, alu_out;
  logic       alu_cout, eq_zero, jump_taken, halted;

  int n_cmp = 0;
  int n_err = 0;

  cpu_core_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .rega(rega), .regb(regb),
    .state(state), .cycle(cycle), .opcode(opcode), .pc(pc),
    .alu_out(alu_out), .alu_cout(alu_cout), .eq_zero(eq_zero),
    .jump_taken(jump_taken), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({state, cycle, pc, opcode, jump_taken, halted} !== 26'd0) begin
      n_err++;
      $display("FAIL reset: state=%0d cycle=%0d pc=%h op=%h jt=%b h=%b, want all 0",
               state, cycle, pc, opcode, jump_taken, halted);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Run one instruction: nibble i of seq is the expected state after edge i+1.
  task automatic test_seq(input string nm, input logic [7:0] op, input int n,
                          input logic [31:0] seq, input logic [7:0] exp_pc);
    do_reset();
    data_in = op;
    for (int i = 0; i < n; i++) begin
      step();
      n_cmp++;
      if (state !== seq[4*i +: 4]) begin
        n_err++;
        $display("FAIL %s step%0d state: got %0d want %0d", nm, i + 1, state, seq[4*i +: 4]);
      end
    end
    n_cmp++;
    if (pc !== exp_pc || cycle !== 4'd0) begin
      n_err++;
      $display("FAIL %s end: pc=%h cycle=%0d want pc=%h cycle=0", nm, pc, cycle, exp_pc);
    end
  endtask

  task automatic test_jump(input string nm, input logic [7:0] op, input logic [7:0] a,
                           input logic [7:0] tgt, input logic exp_jt, input logic [7:0] exp_pc);
    do_reset();
    rega    = a;
    data_in = op;
    step();
    step();
    data_in = tgt;
    step();
    n_cmp++;
    if (state !== 4'd3 || jump_taken !== exp_jt || pc !== 8'h01) begin
      n_err++;
      $display("FAIL %s at JUMP: state=%0d jt=%b pc=%h want 3 %b 01", nm, state, jump_taken, pc, exp_jt);
    end
    step();
    n_cmp++;
    if (pc !== exp_pc || state !== 4'd11) begin
      n_err++;
      $display("FAIL %s after JUMP: pc=%h state=%0d want %h 11", nm, pc, state, exp_pc);
    end
  endtask

  task automatic test_alu();
    logic [7:0] op[10]  = '{8'h40, 8'h40, 8'h48, 8'h48, 8'h78, 8'h50, 8'h58, 8'h60, 8'h68, 8'h70};
    logic [7:0] a[10]   = '{8'hFF, 8'h10, 8'h05, 8'h07, 8'h0F, 8'hFF, 8'h00, 8'hCC, 8'hCC, 8'hCC};
    logic [7:0] b[10]   = '{8'h01, 8'h20, 8'h07, 8'h07, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hAA, 8'hAA};
    logic [7:0] y[10]   = '{8'h00, 8'h30, 8'hFE, 8'h00, 8'hF0, 8'h00, 8'hFF, 8'h88, 8'hEE, 8'h66};
    logic       c[10]   = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
    for (int i = 0; i < 10; i++) begin
      do_reset();
      data_in = op[i];
      rega    = a[i];
      regb    = b[i];
      step();
      step();
      n_cmp++;
      if (state !== 4'd5 || alu_out !== y[i] || alu_cout !== c[i]) begin
        n_err++;
        $display("FAIL alu%0d op=%h: state=%0d y=%h c=%b want 5 %h %b",
                 i, op[i], state, alu_out, alu_cout, y[i], c[i]);
      end
    end
    rega = 8'h00;
    n_cmp++;
    if (eq_zero !== 1'b1) begin
      n_err++;
      $display("FAIL eq_zero: got %b want 1", eq_zero);
    end
  endtask

  task automatic test_halt();
    do_reset();
    data_in = 8'h0F;
    step();
    step();
    data_in = 8'h04;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (state !== 4'd2 || halted !== 1'b1 || pc !== 8'h01 || opcode !== 8'h0F || cycle !== 4'd2) begin
        n_err++;
        $display("FAIL halt%0d: state=%0d h=%b pc=%h op=%h cyc=%0d want 2 1 01 0f 2",
                 i, state, halted, pc, opcode, cycle);
      end
      step();
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (state !== 4'd0 || pc !== 8'h00 || halted !== 1'b0) begin
      n_err++;
      $display("FAIL halt_reset: state=%0d pc=%h h=%b want 0 00 0", state, pc, halted);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    test_jump("jmp_ff", 8'h04, 8'h00, 8'hFF, 1'b1, 8'hFF);
    data_in = 8'h00;
    step();
    step();
    step();
    n_cmp++;
    if (pc !== 8'h00 || state !== 4'd11) begin
      n_err++;
      $display("FAIL wrap: pc=%h state=%0d want 00 11", pc, state);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    data_in = 8'h01;
    step();
    step();
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if (state !== 4'd0 || cycle !== 4'd0 || pc !== 8'h00 || opcode !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset: state=%0d cyc=%0d pc=%h op=%h want 0", state, cycle, pc, opcode);
    end
    @(negedge clk);
    reset = 1'b1;
    step();
    n_cmp++;
    if (state !== 4'd1 || cycle !== 4'd1) begin
      n_err++;
      $display("FAIL mid_reset_resume: state=%0d cyc=%0d want 1 1", state, cycle);
    end
  endtask

  initial begin
    test_reset();
    test_seq("nop",   8'h00, 3, 32'h0000_00B1, 8'h01);
    test_seq("undef", 8'h08, 3, 32'h0000_00B1, 8'h01);
    test_seq("lda",   8'h01, 6, 32'h000B_6801, 8'h02);
    test_seq("ldb",   8'h02, 6, 32'h000B_7801, 8'h02);
    test_seq("sta",   8'h03, 6, 32'h000B_9801, 8'h02);
    test_seq("ldi",   8'h13, 5, 32'h0000_BA01, 8'h02);
    test_seq("out",   8'h07, 4, 32'h0000_0B41, 8'h01);
    test_seq("alu",   8'h40, 4, 32'h0000_0B51, 8'h01);
    test_jump("jmp",     8'h04, 8'h05, 8'h20, 1'b1, 8'h20);
    test_jump("jez_nt",  8'h05, 8'h05, 8'h30, 1'b0, 8'h02);
    test_jump("jez_t",   8'h05, 8'h00, 8'h30, 1'b1, 8'h30);
    test_jump("jnz_t",   8'h06, 8'h05, 8'h40, 1'b1, 8'h40);
    test_jump("jnz_nt",  8'h06, 8'h00, 8'h40, 1'b0, 8'h02);
    test_alu();
    test_halt();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_core_ctrl.md
CPU_CORE_CTRL -- requirements
Module: cpu_core_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data/address width; all values below assume 8.
REQ-002 SHALL have port clk  input  1  single system clock, all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port data_in  input  8  memory/bus data: instruction byte or jump target.
REQ-005 SHALL have ports rega, regb  input  8 each  ALU operands A (accumulator) and B.
REQ-006 SHALL have port state  output  4  current micro-state code.
REQ-007 SHALL have port cycle  output  4  micro-cycle counter within the current instruction.
REQ-008 SHALL have port opcode  output  8  instruction register contents.
REQ-009 SHALL have port pc  output  8  program counter.
REQ-010 SHALL have ports alu_out  output  8, alu_cout  output  1, eq_zero  output  1 (rega==0).
REQ-011 SHALL have ports jump_taken  output  1 and halted  output  1, both combinational.

Function
REQ-012 States SHALL be: FETCH_PC=0, FETCH_INST=1, HALT=2, JUMP=3, OUT_A=4, ALU_OP=5, RAM_A=6, RAM_B=7, LOAD_ADDR=8, STORE_A=9, LDI=10, NEXT=11.
REQ-013 state SHALL be a combinational decode of (cycle, opcode); cycle 0 = FETCH_PC, cycle 1 = FETCH_INST for every instruction.
REQ-014 Sequences from cycle 2:
- NOP 0x00 / undefined opcode: NEXT
- LDA 0x01: FETCH_PC, LOAD_ADDR, RAM_A, NEXT
- LDB 0x02: FETCH_PC, LOAD_ADDR, RAM_B, NEXT
- STA 0x03: FETCH_PC, LOAD_ADDR, STORE_A, NEXT
- JMP 0x04, JEZ 0x05, JNZ 0x06: FETCH_PC, JUMP, NEXT
- OUT 0x07: OUT_A, NEXT
- HLT 0x0F: HALT
- LDI 0x10-0x17 (reg = opcode[2:0]): FETCH_PC, LDI, NEXT
- ALU 01mmm000 (mode = opcode[5:3]): ALU_OP, NEXT
REQ-015 cycle SHALL increment each edge, clear to 0 on the edge leaving NEXT, and hold while in HALT.
REQ-016 opcode SHALL load data_in on the edge ending FETCH_INST; it is otherwise held.
REQ-017 pc SHALL increment by 1 on the edge ending FETCH_INST, LOAD_ADDR, LDI, or a non-taken JUMP, wrapping 0xFF->0x00.
REQ-018 jump_taken = state==JUMP and (JMP, or JEZ with eq_zero, or JNZ with !eq_zero); when taken, pc SHALL load data_in at that edge instead of incrementing.
REQ-019 ALU modes SHALL be combinational: 0 A+B, 1 A-B, 2 A+1, 3 A-1, 4 A&B, 5 A|B, 6 A^B, 7 ~A.
REQ-020 alu_cout SHALL be the carry-out for modes 0 and 2, no-borrow (1 when A>=operand) for modes 1 and 3, and 0 otherwise.
REQ-021 halted = (state==HALT); pc and opcode SHALL freeze while halted, and only reset exits HALT.

Reset
REQ-022 While reset is low, cycle, pc and opcode SHALL be 0, giving state=FETCH_PC, jump_taken=0 and halted=0.
REQ-023 Reset asserted mid-instruction SHALL abort immediately; the first edge after release SHALL perform FETCH_PC.

Structure
REQ-024 A shared package cpu_pkg SHALL hold the opcode constants, state codes and ALU mode codes.
REQ-025 The ALU SHALL be a purely combinational sub-module cpu_alu; the sequencer and PC SHALL live in the top module.

Verification
REQ-026 Reset release, data_in=0x00 -> states 0,1,11,0; pc 0->1; cycle returns to 0.
REQ-027 JMP: data_in=0x04 at FETCH_INST, then 0x20 at JUMP -> jump_taken=1, pc=0x20 after JUMP.
REQ-028 JEZ with rega=5 -> jump_taken=0, pc=2 after JUMP; repeat with rega=0 -> pc=data_in.
REQ-029 ALU: A=0xFF, B=0x01, mode 0 -> alu_out=0x00, cout=1; A=0x05, B=0x07, mode 1 -> alu_out=0xFE, cout=0; mode 7 with A=0x0F -> 0xF0.
REQ-030 HLT 0x0F -> state=2 and halted=1 indefinitely, pc frozen; a reset pulse -> state=0, pc=0.
REQ-031 Run NOPs from pc=0xFF -> pc wraps to 0x00.
